// File: rtl/tts_pkg.sv
// Shared definitions for the truth-table sweeper: state encodings and
// the last-vector helper used to size the sweep.
package tts_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Value of the final input vector (2^n - 1) for an n-input function.
    function automatic int unsigned tts_last_vec(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/tts_delay_line.sv
// Fixed-depth shift register aligning issued {valid, vec} with pipelined
// function results; a plain wire when DEPTH is 0.
module tts_delay_line
    import tts_pkg::*;
#(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused;
            assign w_unused = ^{i_clk, i_rst, i_flush};
            assign o_q      = i_d;
        end else begin : g_sr
            logic [DEPTH-1:0][W-1:0] r_sr;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_sr <= '0;
                end else if (i_flush) begin
                    r_sr <= '0;
                end else begin
                    r_sr[0] <= i_d;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        r_sr[i] <= r_sr[i-1];
                    end
                end
            end

            assign o_q = r_sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive sweeper: issues every N-bit vector once, compares reference and
// candidate results LAT cycles later, and reports count/first-fail/pass.
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned LAT   = 0,
    parameter int unsigned CNT_W = N + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop_on_fail,
    output logic [N-1:0]     vec,
    output logic             vec_valid,
    input  logic             s_ref,
    input  logic             s_dut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [N-1:0]     first_fail_vec,
    output logic             first_fail_valid
);

    localparam logic [N-1:0]     LAST_VEC = N'(tts_last_vec(N));
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(tts_last_vec(N) + 32'd1);

    logic [1:0]       r_state;
    logic [N-1:0]     r_vec;
    logic             r_vec_valid;
    logic             r_stop;
    logic [2:0]       r_drain;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_ff_vec;
    logic             r_ff_valid;

    logic [N:0]       w_dly;
    logic             w_dvalid;
    logic [N-1:0]     w_dvec;
    logic             w_mis;
    logic             w_halt;
    logic             w_accept;
    logic             w_flush;

    assign w_dvalid = w_dly[N];
    assign w_dvec   = w_dly[N-1:0];
    assign w_mis    = w_dvalid & (s_ref ^ s_dut);
    assign w_halt   = r_stop & w_mis;
    assign w_accept = start & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_flush  = w_halt | w_accept;

    tts_delay_line #(
        .W     (N + 1),
        .DEPTH (LAT)
    ) u_dly (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (w_flush),
        .i_d     ({r_vec_valid, r_vec}),
        .o_q     (w_dly)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_vec       <= '0;
            r_vec_valid <= 1'b0;
            r_stop      <= 1'b0;
            r_drain     <= '0;
            r_cnt       <= '0;
            r_ff_vec    <= '0;
            r_ff_valid  <= 1'b0;
        end else begin
            if (w_mis) begin
                if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
                if (!r_ff_valid) begin
                    r_ff_vec   <= w_dvec;
                    r_ff_valid <= 1'b1;
                end
            end

            // A halting mismatch overrides normal sequencing in SWEEP and DRAIN.
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_SWEEP;
                        r_vec       <= '0;
                        r_vec_valid <= 1'b1;
                        r_stop      <= stop_on_fail;
                        r_cnt       <= '0;
                        r_ff_vec    <= '0;
                        r_ff_valid  <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    if (w_halt) begin
                        r_state     <= S_DONE;
                        r_vec_valid <= 1'b0;
                    end else if (r_vec == LAST_VEC) begin
                        r_vec_valid <= 1'b0;
                        r_drain     <= '0;
                        r_state     <= (LAT == 0) ? S_DONE : S_DRAIN;
                    end else begin
                        r_vec <= r_vec + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_halt || r_drain == 3'(LAT - 1)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_drain <= r_drain + 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign vec              = r_vec;
    assign vec_valid        = r_vec_valid;
    assign busy             = (r_state == S_SWEEP) | (r_state == S_DRAIN);
    assign done             = (r_state == S_DONE);
    assign pass             = done & (r_cnt == '0);
    assign mismatch_cnt     = r_cnt;
    assign first_fail_vec   = r_ff_vec;
    assign first_fail_valid = r_ff_valid;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: two sweepers (LAT=0 combinational pair, LAT=3 registered
// pair) driven from a vector table plus hand-written reset/restart sequences.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // LAT=0 instance
    logic       start0 = 1'b0, stop0 = 1'b0;
    logic [3:0] vec0;
    logic       vv0, sref0, sdut0, busy0, done0, pass0, ffv0;
    logic [4:0] cnt0;
    logic [3:0] ff0;

    // LAT=3 instance
    logic       start3 = 1'b0, stop3 = 1'b0;
    logic [3:0] vec3;
    logic       vv3, sref3, sdut3, busy3, done3, pass3, ffv3;
    logic [4:0] cnt3;
    logic [3:0] ff3;

    int mode0 = 0;  // 0: identical, 1: candidate is the OR variant
    int mode3 = 0;  // 0: identical, 1: invert at 1010, 2: at 1111, 3: at 0000

    function automatic logic f_ref(input logic [3:0] v);
        return v[3] & ~&v[2:0];
    endfunction

    function automatic logic f_or(input logic [3:0] v);
        return v[3] | ~&v[2:0];
    endfunction

    assign sref0 = f_ref(vec0);
    assign sdut0 = (mode0 == 1) ? f_or(vec0) : f_ref(vec0);

    logic [2:0] p_ref, p_dut;
    logic       inv3;
    always_comb begin
        inv3 = 1'b0;
        if (mode3 == 1 && vec3 == 4'b1010) inv3 = 1'b1;
        if (mode3 == 2 && vec3 == 4'b1111) inv3 = 1'b1;
        if (mode3 == 3 && vec3 == 4'b0000) inv3 = 1'b1;
    end
    always @(posedge clk) begin
        p_ref <= {p_ref[1:0], f_ref(vec3)};
        p_dut <= {p_dut[1:0], f_ref(vec3) ^ inv3};
    end
    assign sref3 = p_ref[2];
    assign sdut3 = p_dut[2];

    truth_table_sweeper #(.N(4), .LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .stop_on_fail(stop0),
        .vec(vec0), .vec_valid(vv0), .s_ref(sref0), .s_dut(sdut0),
        .busy(busy0), .done(done0), .pass(pass0), .mismatch_cnt(cnt0),
        .first_fail_vec(ff0), .first_fail_valid(ffv0)
    );

    truth_table_sweeper #(.N(4), .LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .stop_on_fail(stop3),
        .vec(vec3), .vec_valid(vv3), .s_ref(sref3), .s_dut(sdut3),
        .busy(busy3), .done(done3), .pass(pass3), .mismatch_cnt(cnt3),
        .first_fail_vec(ff3), .first_fail_valid(ffv3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Start a sweep and wait (bounded) for done; returns cycles from the
    // start edge to done, busy-high samples and vector-sequence errors.
    task automatic run_sweep(input int use3, input int stop,
                             output int cyc, output int bcnt, output int verr);
        @(negedge clk);
        if (use3 != 0) begin start3 = 1'b1; stop3 = (stop != 0); end
        else           begin start0 = 1'b1; stop0 = (stop != 0); end
        @(negedge clk);
        start0 = 1'b0;
        start3 = 1'b0;
        cyc = 0; bcnt = 0; verr = 0;
        while (((use3 != 0) ? done3 : done0) == 1'b0 && cyc < 200) begin
            if (((use3 != 0) ? busy3 : busy0) == 1'b1) bcnt++;
            if (((use3 != 0) ? vv3 : vv0) == 1'b1 &&
                int'((use3 != 0) ? vec3 : vec0) != cyc) verr++;
            @(negedge clk);
            cyc++;
        end
    endtask

    typedef struct {
        int use3; int mode; int stop;
        int e_cyc; int e_cnt; int e_ffv; int e_ff; int e_pass;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int cyc, bcnt, verr, hold;
        bit pulsed;
        string nm;

        tbl[0]  = '{0, 0, 0, 16, 0, 0, 0,  1};
        tbl[1]  = '{0, 1, 0, 16, 8, 1, 0,  0};
        tbl[2]  = '{0, 1, 0, 16, 8, 1, 0,  0};
        tbl[3]  = '{0, 1, 1, 1,  1, 1, 0,  0};
        tbl[4]  = '{0, 0, 1, 16, 0, 0, 0,  1};
        tbl[5]  = '{1, 0, 0, 19, 0, 0, 0,  1};
        tbl[6]  = '{1, 1, 0, 19, 1, 1, 10, 0};
        tbl[7]  = '{1, 2, 0, 19, 1, 1, 15, 0};
        tbl[8]  = '{1, 3, 0, 19, 1, 1, 0,  0};
        tbl[9]  = '{1, 1, 1, 14, 1, 1, 10, 0};
        tbl[10] = '{1, 3, 1, 4,  1, 1, 0,  0};

        // Reset state
        #12;
        chk("rst_vec",   int'(vec0), 0);
        chk("rst_vv",    int'(vv0),  0);
        chk("rst_busy",  int'(busy0), 0);
        chk("rst_done",  int'(done0), 0);
        chk("rst_pass",  int'(pass0), 0);
        chk("rst_cnt",   int'(cnt0), 0);
        chk("rst_ffv",   int'(ffv0), 0);
        chk("rst_done3", int'(done3), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].use3 != 0) mode3 = tbl[i].mode;
            else                  mode0 = tbl[i].mode;
            run_sweep(tbl[i].use3, tbl[i].stop, cyc, bcnt, verr);
            nm = $sformatf("row%0d", i);
            chk({nm, "_cycles"}, cyc,  tbl[i].e_cyc);
            chk({nm, "_busy"},   bcnt, tbl[i].e_cyc);
            chk({nm, "_vecseq"}, verr, 0);
            if (tbl[i].use3 != 0) begin
                chk({nm, "_cnt"},  int'(cnt3),  tbl[i].e_cnt);
                chk({nm, "_ffv"},  int'(ffv3),  tbl[i].e_ffv);
                chk({nm, "_ff"},   int'(ff3),   tbl[i].e_ff);
                chk({nm, "_pass"}, int'(pass3), tbl[i].e_pass);
            end else begin
                chk({nm, "_cnt"},  int'(cnt0),  tbl[i].e_cnt);
                chk({nm, "_ffv"},  int'(ffv0),  tbl[i].e_ffv);
                chk({nm, "_ff"},   int'(ff0),   tbl[i].e_ff);
                chk({nm, "_pass"}, int'(pass0), tbl[i].e_pass);
            end
            // Outputs must hold in DONE even while the functions still disagree
            repeat (3) @(negedge clk);
            if (tbl[i].use3 != 0) begin
                chk({nm, "_hold_cnt"}, int'(cnt3), tbl[i].e_cnt);
                chk({nm, "_hold_vv"},  int'(vv3),  0);
                chk({nm, "_hold_done"}, int'(done3), 1);
            end else begin
                chk({nm, "_hold_cnt"}, int'(cnt0), tbl[i].e_cnt);
                chk({nm, "_hold_vv"},  int'(vv0),  0);
                chk({nm, "_hold_done"}, int'(done0), 1);
            end
        end

        // Asynchronous reset in the middle of a failing sweep
        mode0 = 1;
        @(negedge clk);
        start0 = 1'b1; stop0 = 1'b0;
        @(negedge clk);
        start0 = 1'b0;
        hold = 0;
        while (vec0 != 4'd7 && hold < 40) begin
            @(negedge clk);
            hold++;
        end
        chk("mid_reached_vec7", int'(vec0), 7);
        chk("mid_cnt_before",   int'(cnt0), 7);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_vec",  int'(vec0),  0);
        chk("mid_rst_vv",   int'(vv0),   0);
        chk("mid_rst_busy", int'(busy0), 0);
        chk("mid_rst_cnt",  int'(cnt0),  0);
        chk("mid_rst_ffv",  int'(ffv0),  0);
        chk("mid_rst_ff",   int'(ff0),   0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_idle_done", int'(done0), 0);
        chk("mid_idle_busy", int'(busy0), 0);
        mode0 = 0;
        run_sweep(0, 0, cyc, bcnt, verr);
        chk("post_rst_cycles", cyc, 16);
        chk("post_rst_cnt",    int'(cnt0), 0);
        chk("post_rst_pass",   int'(pass0), 1);
        chk("post_rst_vecseq", verr, 0);

        // Start (with stop_on_fail set) pulsed mid-sweep must be ignored
        mode0 = 1;
        @(negedge clk);
        start0 = 1'b1; stop0 = 1'b0;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 0; pulsed = 1'b0;
        while (done0 == 1'b0 && cyc < 200) begin
            if (vec0 == 4'd5 && !pulsed) begin
                start0 = 1'b1; stop0 = 1'b1; pulsed = 1'b1;
            end else begin
                start0 = 1'b0; stop0 = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start0 = 1'b0;
        chk("busy_start_cycles", cyc, 16);
        chk("busy_start_cnt",    int'(cnt0), 8);
        chk("busy_start_ff",     int'(ff0), 0);
        chk("busy_start_pass",   int'(pass0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential exhaustive checker for N-input single-output Boolean functions; replaces hand-written per-vector stimulus lists.
- Drives every input vector 0 .. 2^N-1 to two external implementations of the same function (reference and candidate) and compares their outputs.
- Reports mismatch count, first failing vector, and pass/fail.
- Sits in the bench/lab harness between the vector source and any pair of combinational or pipelined function modules.

Parameters:
- N, 4, number of function inputs; legal range 1..16.
- LAT, 0, pipeline latency in cycles from vec to s_ref/s_dut valid; legal range 0..7.
- CNT_W, N+1, width of mismatch_cnt; derived, do not override.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a sweep from IDLE or DONE.
- stop_on_fail  in  1  sampled at start; 1 = halt at first mismatch.
- vec  out  N  current input vector to both implementations.
- vec_valid  out  1  vec is a live stimulus this cycle.
- s_ref  in  1  reference output for the vector issued LAT cycles earlier.
- s_dut  in  1  candidate output, same timing as s_ref.
- busy  out  1  high in SWEEP and DRAIN.
- done  out  1  high in DONE, held until the next accepted start or reset.
- pass  out  1  valid when done=1; 1 iff mismatch_cnt==0.
- mismatch_cnt  out  CNT_W  number of compared vectors with s_ref != s_dut.
- first_fail_vec  out  N  vector of the first mismatch.
- first_fail_valid  out  1  first_fail_vec holds a captured vector.

Behaviour:
- Reset (async, any state, including mid-sweep):
  - state=IDLE.
  - vec=0, vec_valid=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail_vec=0, first_fail_valid=0.
  - Delay line cleared; in-flight results discarded.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE: start=1 -> SWEEP.
  - Same edge: clear counters and first_fail, latch stop_on_fail, vec=0, vec_valid=1.
- SWEEP: one vector per cycle, vec increments by 1.
  - Each issued vec is pushed into a LAT-deep shift register of {valid, vec}. LAT=0 means the compare uses the current vec.
  - When vec==2^N-1 is issued: vec_valid=0 next cycle; LAT=0 -> DONE, else -> DRAIN. vec does not wrap; it holds 2^N-1.
- DRAIN: no new vectors; runs exactly LAT cycles, then -> DONE.
- Compare, every cycle the delayed valid bit is 1:
  - If s_ref != s_dut: mismatch_cnt += 1 (saturates at 2^N, which cannot be exceeded).
  - If first_fail_valid==0: capture the delayed vec into first_fail_vec and set first_fail_valid=1.
- stop_on_fail latched=1 and mismatch detected:
  - Next state DONE regardless of SWEEP/DRAIN.
  - vec_valid=0; the delay line is flushed and later results are ignored.
  - mismatch_cnt=1.
- DONE: pass = (mismatch_cnt==0). Outputs hold. start=1 -> restart as from IDLE.
- start while busy is ignored; no effect on the sweep.
- Latency: full sweep with no stop takes 2^N + LAT cycles from the start edge to done=1.

Decomposition:
- Shared package (tts_pkg):
  - state encoding constants S_IDLE=2'd0, S_SWEEP=2'd1, S_DRAIN=2'd2, S_DONE=2'd3.
  - localparam helper for 2^N last-vector value.
- One sub-module: tts_delay_line. Parametrised by width (N+1) and depth LAT, with async clear and flush. It is a pure passthrough when LAT=0.

Test Plan:
- N=4, LAT=0, s_ref = s_dut = vec[3] & ~&vec[2:0], start -> vec steps 0..15 over 16 cycles; done=1 at cycle 16; pass=1; mismatch_cnt=0; first_fail_valid=0.
- N=4, LAT=0, s_ref = vec[3] & ~&vec[2:0], s_dut = vec[3] | ~&vec[2:0], stop_on_fail=0 -> mismatches at 0000..0110 and 1111; mismatch_cnt=8, first_fail_vec=4'b0000, pass=0.
- Same functions, stop_on_fail=1 -> done one cycle after vec=0 compares; mismatch_cnt=1; first_fail_vec=0; vec_valid low from then on.
- N=4, LAT=3, functions registered 3 deep, identical except candidate inverted only at vec=4'b1010 -> busy for 19 cycles; mismatch_cnt=1; first_fail_vec=4'b1010.
- Assert rst at vec=7 mid-sweep -> all outputs 0 asynchronously, state IDLE. A new start sweeps cleanly from 0 with no stale counts.
- Pulse start during SWEEP at vec=5 -> ignored, sweep completes normally. A start pulse in DONE -> counters clear and a second sweep gives identical results.
